// File: rtl/bounce_motion_ctrl_pkg.sv
// Shared types and constants for the bouncing-banner motion scheduler.
// Holds the FSM encoding, screen defaults, step width, clamp limits and palette size.
package bounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_X = 2'd1,
    CALC_Y = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int SPEED_W      = 2;
  localparam int STEP_W       = SPEED_W + 1;
  localparam int POS_W        = 10;
  localparam int DIM_MIN      = 8;
  localparam int PALETTE_SIZE = 8;
  localparam int COLOR_W      = $clog2(PALETTE_SIZE);

  // Keep text dimensions inside [DIM_MIN, hi] so max = screen - size never goes negative.
  function automatic logic [POS_W-1:0] clamp_dim(input logic [POS_W-1:0] req,
                                                 input logic [POS_W-1:0] hi);
    logic [POS_W-1:0] res;
    res = req;
    if (req < POS_W'(DIM_MIN)) res = POS_W'(DIM_MIN);
    else if (req > hi)         res = hi;
    return res;
  endfunction

endpackage

// File: rtl/bounce_motion_ctrl_axis_stepper.sv
// Combinational single-axis motion step with edge bounce.
// Arithmetic is one bit wider than the position so pos+step and compares never wrap.
module axis_stepper
  import bounce_pkg::*;
(
  input  logic [POS_W-1:0]  pos,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic [POS_W-1:0]  max_pos,
  output logic [POS_W-1:0]  next_pos,
  output logic              next_dir,
  output logic              hit
);

  logic [POS_W:0] pos_w;
  logic [POS_W:0] max_w;
  logic [POS_W:0] step_w;
  logic [POS_W:0] sum_w;

  assign pos_w  = {1'b0, pos};
  assign max_w  = {1'b0, max_pos};
  assign step_w = (POS_W+1)'(step);
  assign sum_w  = pos_w + step_w;

  always_comb begin
    next_pos = pos;
    next_dir = dir;
    hit      = 1'b0;
    if (max_pos == '0) begin
      // Text fills the axis: pin to origin, no bounce.
      next_pos = '0;
      next_dir = 1'b0;
    end else if (pos_w > max_w) begin
      // Text grew under the banner: snap back inside and treat as a bounce.
      next_pos = max_pos;
      next_dir = 1'b1;
      hit      = 1'b1;
    end else if (!dir) begin
      if (sum_w >= max_w) begin
        next_pos = max_pos;
        next_dir = 1'b1;
        hit      = 1'b1;
      end else begin
        next_pos = sum_w[POS_W-1:0];
      end
    end else begin
      if (pos_w <= step_w) begin
        next_pos = '0;
        next_dir = 1'b0;
        hit      = 1'b1;
      end else begin
        next_pos = pos - POS_W'(step);
      end
    end
  end

endmodule

// File: rtl/bounce_motion_ctrl.sv
// Per-frame banner motion scheduler: X then Y are stepped into shadows, then committed in one edge.
// Handshake: a config transfer happens on a clk edge where cfg_valid && cfg_ready; cfg_ready is only high in IDLE without a tick.
module bounce_motion_ctrl
  import bounce_pkg::*;
#(
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int SCREEN_H   = SCREEN_H_DEF,
  parameter int TEXT_W_DEF = 560,
  parameter int TEXT_H_DEF = 32,
  parameter int INIT_X     = 10,
  parameter int INIT_Y     = 10,
  parameter int INIT_COLOR = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               pause,
  input  logic [SPEED_W-1:0] speed,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [POS_W-1:0]   cfg_text_w,
  input  logic [POS_W-1:0]   cfg_text_h,
  output logic [POS_W-1:0]   pos_x,
  output logic [POS_W-1:0]   pos_y,
  output logic [COLOR_W-1:0] color_index,
  output logic               busy,
  output logic               bounce_pulse,
  output state_t             state_dbg
);

  state_t state, next_state;

  logic              dir_x, dir_y;
  logic [POS_W-1:0]  text_w, text_h;
  logic [STEP_W-1:0] step_q;
  logic [POS_W-1:0]  sh_x, sh_y;
  logic              sh_dir_x, sh_dir_y, sh_hit_x, sh_hit_y;

  logic [POS_W-1:0]  max_x, max_y;
  logic              sel_y;
  logic [POS_W-1:0]  st_pos, st_max, st_next_pos;
  logic              st_dir, st_next_dir, st_hit;

  assign max_x = POS_W'(SCREEN_W) - text_w;
  assign max_y = POS_W'(SCREEN_H) - text_h;

  // One stepper shared between the two CALC states.
  assign sel_y  = (state == CALC_Y);
  assign st_pos = sel_y ? pos_y : pos_x;
  assign st_dir = sel_y ? dir_y : dir_x;
  assign st_max = sel_y ? max_y : max_x;

  axis_stepper u_stepper (
    .pos      (st_pos),
    .dir      (st_dir),
    .step     (step_q),
    .max_pos  (st_max),
    .next_pos (st_next_pos),
    .next_dir (st_next_dir),
    .hit      (st_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (frame_tick && !pause) next_state = CALC_X;
      CALC_X:  next_state = CALC_Y;
      CALC_Y:  next_state = COMMIT;
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    cfg_ready = (state == IDLE) && !frame_tick;
    state_dbg = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x        <= POS_W'(INIT_X);
      pos_y        <= POS_W'(INIT_Y);
      dir_x        <= 1'b0;
      dir_y        <= 1'b0;
      color_index  <= COLOR_W'(INIT_COLOR);
      text_w       <= POS_W'(TEXT_W_DEF);
      text_h       <= POS_W'(TEXT_H_DEF);
      step_q       <= STEP_W'(1);
      sh_x         <= '0;
      sh_y         <= '0;
      sh_dir_x     <= 1'b0;
      sh_dir_y     <= 1'b0;
      sh_hit_x     <= 1'b0;
      sh_hit_y     <= 1'b0;
      bounce_pulse <= 1'b0;
    end else begin
      bounce_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick && !pause) begin
            step_q <= {1'b0, speed} + STEP_W'(1);
          end else if (cfg_valid && cfg_ready) begin
            text_w <= clamp_dim(cfg_text_w, POS_W'(SCREEN_W));
            text_h <= clamp_dim(cfg_text_h, POS_W'(SCREEN_H));
          end
        end
        CALC_X: begin
          sh_x     <= st_next_pos;
          sh_dir_x <= st_next_dir;
          sh_hit_x <= st_hit;
        end
        CALC_Y: begin
          sh_y     <= st_next_pos;
          sh_dir_y <= st_next_dir;
          sh_hit_y <= st_hit;
        end
        COMMIT: begin
          pos_x <= sh_x;
          pos_y <= sh_y;
          dir_x <= sh_dir_x;
          dir_y <= sh_dir_y;
          // A corner bounce advances the colour only once.
          if (sh_hit_x || sh_hit_y) color_index <= color_index + COLOR_W'(1);
          bounce_pulse <= sh_hit_x || sh_hit_y;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bounce_motion_ctrl.sv
// Directed testbench for bounce_motion_ctrl: motion, bounces, pause, config clamp and reset abort.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bounce_motion_ctrl;
  import bounce_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        pause = 1'b0;
  logic [1:0]  speed = 2'd0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [9:0]  cfg_text_w = 10'd0;
  logic [9:0]  cfg_text_h = 10'd0;
  logic [9:0]  pos_x, pos_y;
  logic [2:0]  color_index;
  logic        busy, bounce_pulse;
  state_t      state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bounce_motion_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .pause        (pause),
    .speed        (speed),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_text_w   (cfg_text_w),
    .cfg_text_h   (cfg_text_h),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .color_index  (color_index),
    .busy         (busy),
    .bounce_pulse (bounce_pulse),
    .state_dbg    (state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1;
    frame_tick = 1'b0;
    cfg_valid = 1'b0;
    pause = 1'b0;
    speed = 2'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Called on a falling edge in IDLE; returns on the falling edge after the commit edge.
  task automatic run_frame();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_cfg(input logic [9:0] w, input logic [9:0] h);
    cfg_text_w = w;
    cfg_text_h = h;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++; if (pos_x !== 10'd10) begin errors++; $display("FAIL reset_pos_x: got %0d expected 10", pos_x); end
    checks++; if (pos_y !== 10'd10) begin errors++; $display("FAIL reset_pos_y: got %0d expected 10", pos_y); end
    checks++; if (color_index !== 3'd1) begin errors++; $display("FAIL reset_color: got %0d expected 1", color_index); end
    checks++; if (busy !== 1'b0 || bounce_pulse !== 1'b0) begin errors++; $display("FAIL reset_busy_pulse: got busy=%0b pulse=%0b expected 0 0", busy, bounce_pulse); end
    checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready: got %0b expected 1", cfg_ready); end
    do_reset();
  endtask

  task automatic test_single_frame();
    int busy_cnt;
    do_reset();
    busy_cnt = 0;
    frame_tick = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (i == 3) begin
        checks++; if (pos_x !== 10'd11 || pos_y !== 10'd11) begin errors++; $display("FAIL single_pos: got (%0d,%0d) expected (11,11)", pos_x, pos_y); end
        checks++; if (color_index !== 3'd1) begin errors++; $display("FAIL single_color: got %0d expected 1", color_index); end
        checks++; if (bounce_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse: got %0b expected 0", bounce_pulse); end
      end
      if (i == 1) begin
        checks++; if (pos_x !== 10'd10) begin errors++; $display("FAIL single_no_early_commit: got %0d expected 10", pos_x); end
      end
    end
    checks++; if (busy_cnt != 3) begin errors++; $display("FAIL single_busy_cycles: got %0d expected 3", busy_cnt); end
  endtask

  task automatic test_x_bounce();
    do_reset();
    speed = 2'd3;
    repeat (17) run_frame();
    checks++; if (pos_x !== 10'd78 || pos_y !== 10'd78) begin errors++; $display("FAIL xb_pre_pos: got (%0d,%0d) expected (78,78)", pos_x, pos_y); end
    run_frame();
    checks++; if (pos_x !== 10'd80 || pos_y !== 10'd82) begin errors++; $display("FAIL xb_pos: got (%0d,%0d) expected (80,82)", pos_x, pos_y); end
    checks++; if (color_index !== 3'd2) begin errors++; $display("FAIL xb_color: got %0d expected 2", color_index); end
    checks++; if (bounce_pulse !== 1'b1) begin errors++; $display("FAIL xb_pulse: got %0b expected 1", bounce_pulse); end
    @(negedge clk);
    checks++; if (bounce_pulse !== 1'b0) begin errors++; $display("FAIL xb_pulse_width: got %0b expected 0", bounce_pulse); end
    run_frame();
    checks++; if (pos_x !== 10'd76 || pos_y !== 10'd86 || color_index !== 3'd2) begin errors++; $display("FAIL xb_return: got (%0d,%0d) c=%0d expected (76,86) c=2", pos_x, pos_y, color_index); end
  endtask

  task automatic test_corner();
    do_reset();
    send_cfg(10'd560, 10'd400);
    speed = 2'd3;
    repeat (17) run_frame();
    run_frame();
    checks++; if (pos_x !== 10'd80 || pos_y !== 10'd80) begin errors++; $display("FAIL corner_pos: got (%0d,%0d) expected (80,80)", pos_x, pos_y); end
    checks++; if (color_index !== 3'd2) begin errors++; $display("FAIL corner_color: got %0d expected 2", color_index); end
    checks++; if (bounce_pulse !== 1'b1) begin errors++; $display("FAIL corner_pulse: got %0b expected 1", bounce_pulse); end
    @(negedge clk);
    checks++; if (bounce_pulse !== 1'b0) begin errors++; $display("FAIL corner_pulse_width: got %0b expected 0", bounce_pulse); end
    run_frame();
    checks++; if (pos_x !== 10'd76 || pos_y !== 10'd76 || color_index !== 3'd2) begin errors++; $display("FAIL corner_return: got (%0d,%0d) c=%0d expected (76,76) c=2", pos_x, pos_y, color_index); end
  endtask

  task automatic test_pause_and_drop();
    int busy_seen;
    do_reset();
    run_frame();
    pause = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      if (busy === 1'b1) busy_seen++;
      repeat (2) begin
        @(negedge clk);
        if (busy === 1'b1) busy_seen++;
      end
    end
    checks++; if (busy_seen != 0) begin errors++; $display("FAIL pause_busy: got %0d busy cycles expected 0", busy_seen); end
    checks++; if (pos_x !== 10'd11 || pos_y !== 10'd11 || color_index !== 3'd1) begin errors++; $display("FAIL pause_hold: got (%0d,%0d) c=%0d expected (11,11) c=1", pos_x, pos_y, color_index); end
    pause = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (pos_x !== 10'd12 || pos_y !== 10'd12) begin errors++; $display("FAIL drop_one_step: got (%0d,%0d) expected (12,12)", pos_x, pos_y); end
    repeat (4) @(negedge clk);
    checks++; if (pos_x !== 10'd12 || busy !== 1'b0) begin errors++; $display("FAIL drop_no_second: got x=%0d busy=%0b expected x=12 busy=0", pos_x, busy); end
  endtask

  task automatic test_cfg_clamp();
    int waits;
    do_reset();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    cfg_text_w = 10'd700;
    cfg_text_h = 10'd32;
    cfg_valid = 1'b1;
    checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_busy: got %0b expected 0", cfg_ready); end
    waits = 0;
    while (waits < 10) begin
      @(negedge clk);
      waits++;
      if (cfg_ready === 1'b1) break;
    end
    checks++; if (waits != 3) begin errors++; $display("FAIL cfg_wait: got %0d cycles expected 3", waits); end
    checks++; if (pos_x !== 10'd11 || pos_y !== 10'd11) begin errors++; $display("FAIL cfg_old_dims_frame: got (%0d,%0d) expected (11,11)", pos_x, pos_y); end
    @(negedge clk);
    cfg_valid = 1'b0;
    run_frame();
    checks++; if (pos_x !== 10'd0 || pos_y !== 10'd12) begin errors++; $display("FAIL cfg_clamp_hi: got (%0d,%0d) expected (0,12)", pos_x, pos_y); end
    checks++; if (color_index !== 3'd1 || bounce_pulse !== 1'b0) begin errors++; $display("FAIL cfg_clamp_nohit: got c=%0d pulse=%0b expected c=1 pulse=0", color_index, bounce_pulse); end
    send_cfg(10'd3, 10'd1000);
    run_frame();
    checks++; if (pos_x !== 10'd1 || pos_y !== 10'd0) begin errors++; $display("FAIL cfg_clamp_lo: got (%0d,%0d) expected (1,0)", pos_x, pos_y); end
    checks++; if (color_index !== 3'd1) begin errors++; $display("FAIL cfg_clamp_lo_color: got %0d expected 1", color_index); end
  endtask

  task automatic test_beyond_max();
    do_reset();
    speed = 2'd3;
    repeat (5) run_frame();
    send_cfg(10'd620, 10'd32);
    run_frame();
    checks++; if (pos_x !== 10'd20 || pos_y !== 10'd34) begin errors++; $display("FAIL shrink_pos: got (%0d,%0d) expected (20,34)", pos_x, pos_y); end
    checks++; if (color_index !== 3'd2 || bounce_pulse !== 1'b1) begin errors++; $display("FAIL shrink_hit: got c=%0d pulse=%0b expected c=2 pulse=1", color_index, bounce_pulse); end
    repeat (4) run_frame();
    checks++; if (pos_x !== 10'd4 || pos_y !== 10'd50) begin errors++; $display("FAIL left_pre: got (%0d,%0d) expected (4,50)", pos_x, pos_y); end
    run_frame();
    checks++; if (pos_x !== 10'd0 || pos_y !== 10'd54) begin errors++; $display("FAIL left_bounce_pos: got (%0d,%0d) expected (0,54)", pos_x, pos_y); end
    checks++; if (color_index !== 3'd3 || bounce_pulse !== 1'b1) begin errors++; $display("FAIL left_bounce_hit: got c=%0d pulse=%0b expected c=3 pulse=1", color_index, bounce_pulse); end
    run_frame();
    checks++; if (pos_x !== 10'd4) begin errors++; $display("FAIL left_return: got %0d expected 4", pos_x); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_frame();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    checks++; if (state_dbg !== CALC_Y) begin errors++; $display("FAIL mid_state: got %0d expected %0d", state_dbg, CALC_Y); end
    #1 reset = 1'b1;
    #1;
    checks++; if (pos_x !== 10'd10 || pos_y !== 10'd10 || color_index !== 3'd1) begin errors++; $display("FAIL mid_reset_out: got (%0d,%0d) c=%0d expected (10,10) c=1", pos_x, pos_y, color_index); end
    checks++; if (busy !== 1'b0 || state_dbg !== IDLE) begin errors++; $display("FAIL mid_reset_idle: got busy=%0b state=%0d expected 0 0", busy, state_dbg); end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pos_x !== 10'd10 || bounce_pulse !== 1'b0) begin errors++; $display("FAIL mid_no_partial: got x=%0d pulse=%0b expected 10 0", pos_x, bounce_pulse); end
    run_frame();
    checks++; if (pos_x !== 10'd11 || pos_y !== 10'd11) begin errors++; $display("FAIL mid_first_tick: got (%0d,%0d) expected (11,11)", pos_x, pos_y); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_x_bounce();
    test_corner();
    test_pause_and_drop();
    test_cfg_clamp();
    test_beyond_max();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
